// File: rtl/stage_writeback_pkg.sv
// Shared constants and types for the writeback stage: opcodes, ALU ops,
// architectural registers, exception codes and the multdiv FSM states.
package stage_writeback_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   localparam int REG_RA     = 31;
   localparam int REG_STATUS = 30;

   localparam int EXC_ADD  = 1;
   localparam int EXC_ADDI = 2;
   localparam int EXC_SUB  = 3;
   localparam int EXC_MUL  = 4;
   localparam int EXC_DIV  = 5;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_WAIT = 2'd1,
      MD_HOLD = 2'd2
   } md_state_t;

endpackage

// File: rtl/stage_writeback_select.sv
// Pipeline write decision: maps latched M/W fields to {we, reg, data}.
// Overflow on add/addi/sub redirects the write to the status register.
module writeback_select
   import stage_writeback_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int REG_BITS = 5
) (
   input  logic                valid,
   input  logic [4:0]          opcode,
   input  logic [4:0]          rd,
   input  logic [4:0]          alu_op,
   input  logic [WIDTH-1:0]    alu,
   input  logic [WIDTH-1:0]    mem,
   input  logic [WIDTH-1:0]    pc1,
   input  logic                ovf,
   output logic                we,
   output logic [REG_BITS-1:0] wreg,
   output logic [WIDTH-1:0]    wdata
);

   logic                hit;
   logic [REG_BITS-1:0] dst;
   logic [WIDTH-1:0]    val;

   always_comb begin
      hit = 1'b0;
      dst = REG_BITS'(rd);
      val = alu;
      if (valid) begin
         case (opcode)
            OP_RTYPE: begin
               case (alu_op)
                  ALU_ADD: begin
                     hit = 1'b1;
                     if (ovf) begin
                        dst = REG_BITS'(REG_STATUS);
                        val = WIDTH'(EXC_ADD);
                     end
                  end
                  ALU_SUB: begin
                     hit = 1'b1;
                     if (ovf) begin
                        dst = REG_BITS'(REG_STATUS);
                        val = WIDTH'(EXC_SUB);
                     end
                  end
                  ALU_AND, ALU_OR, ALU_SLL, ALU_SRA: hit = 1'b1;
                  default: hit = 1'b0;  // mul/div retire through the multdiv path
               endcase
            end
            OP_ADDI: begin
               hit = 1'b1;
               if (ovf) begin
                  dst = REG_BITS'(REG_STATUS);
                  val = WIDTH'(EXC_ADDI);
               end
            end
            OP_LW: begin
               hit = 1'b1;
               val = mem;
            end
            OP_JAL: begin
               hit = 1'b1;
               dst = REG_BITS'(REG_RA);
               val = pc1;
            end
            OP_SETX: begin
               hit = 1'b1;
               dst = REG_BITS'(REG_STATUS);
            end
            default: hit = 1'b0;
         endcase
      end
   end

   assign we    = hit && (dst != '0);
   assign wreg  = we ? dst : '0;
   assign wdata = we ? val : '0;

endmodule

// File: rtl/stage_writeback.sv
// Writeback stage: M/W latch, register-file write port arbitration between the
// pipeline and the multi-cycle multdiv unit, and multdiv hazard reporting.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   MD_IDLE | no mul/div outstanding
//   MD_WAIT | mul/div issued, waiting for md_rdy
//   MD_HOLD | result buffered, waiting for a cycle with no pipeline write
module stage_writeback
   import stage_writeback_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int REG_BITS = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [31:0]         in_insn,
   input  logic [WIDTH-1:0]    in_alu_result,
   input  logic [WIDTH-1:0]    in_mem_data,
   input  logic [WIDTH-1:0]    in_pc_plus1,
   input  logic                in_ovf,
   input  logic                md_issue,
   input  logic [REG_BITS-1:0] md_rd,
   input  logic                md_is_div,
   input  logic                md_rdy,
   input  logic [WIDTH-1:0]    md_result,
   input  logic                md_exception,
   output logic                ctrl_writeEnable,
   output logic [REG_BITS-1:0] ctrl_writeReg,
   output logic [WIDTH-1:0]    data_writeReg,
   output logic                md_busy,
   output logic [REG_BITS-1:0] md_dest
);

   logic             w_valid;
   logic [31:0]      w_insn;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH-1:0] w_mem;
   logic [WIDTH-1:0] w_pc1;
   logic             w_ovf;

   always_ff @(posedge clock) begin
      if (reset) begin
         w_valid <= 1'b0;
         w_insn  <= '0;
         w_alu   <= '0;
         w_mem   <= '0;
         w_pc1   <= '0;
         w_ovf   <= 1'b0;
      end else begin
         w_valid <= in_valid;
         w_insn  <= in_insn;
         w_alu   <= in_alu_result;
         w_mem   <= in_mem_data;
         w_pc1   <= in_pc_plus1;
         w_ovf   <= in_ovf;
      end
   end

   logic unused_insn_bits;
   assign unused_insn_bits = ^{w_insn[21:7], w_insn[1:0]};

   logic                pipe_we;
   logic [REG_BITS-1:0] pipe_reg;
   logic [WIDTH-1:0]    pipe_data;

   writeback_select #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) u_select (
      .valid  (w_valid),
      .opcode (w_insn[31:27]),
      .rd     (w_insn[26:22]),
      .alu_op (w_insn[6:2]),
      .alu    (w_alu),
      .mem    (w_mem),
      .pc1    (w_pc1),
      .ovf    (w_ovf),
      .we     (pipe_we),
      .wreg   (pipe_reg),
      .wdata  (pipe_data)
   );

   md_state_t           state, state_nxt;
   logic [REG_BITS-1:0] md_reg_q;
   logic                md_div_q;
   logic [WIDTH-1:0]    buf_data;
   logic [REG_BITS-1:0] rdy_reg;
   logic [WIDTH-1:0]    rdy_data;
   logic                retire_now;
   logic                issue_ok;

   assign rdy_reg    = md_exception ? REG_BITS'(REG_STATUS) : md_reg_q;
   assign rdy_data   = md_exception ? (md_div_q ? WIDTH'(EXC_DIV) : WIDTH'(EXC_MUL)) : md_result;
   assign retire_now = (state == MD_WAIT) && md_rdy && !pipe_we;
   // a new op may start only from IDLE or in the very cycle WAIT retires
   assign issue_ok   = md_issue && ((state == MD_IDLE) || retire_now);

   always_ff @(posedge clock) begin
      if (reset) state <= MD_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (md_issue) state_nxt = MD_WAIT;
         MD_WAIT: begin
            if (md_rdy) begin
               if (pipe_we)       state_nxt = MD_HOLD;
               else if (md_issue) state_nxt = MD_WAIT;
               else               state_nxt = MD_IDLE;
            end
         end
         MD_HOLD: if (!pipe_we) state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         md_reg_q <= '0;
         md_div_q <= 1'b0;
         buf_data <= '0;
      end else if (issue_ok) begin
         md_reg_q <= md_rd;
         md_div_q <= md_is_div;
      end else if ((state == MD_WAIT) && md_rdy && pipe_we) begin
         md_reg_q <= rdy_reg;
         buf_data <= rdy_data;
      end
   end

   logic                md_fire;
   logic [REG_BITS-1:0] md_wreg;
   logic [WIDTH-1:0]    md_wdata;

   always_comb begin
      md_fire  = 1'b0;
      md_wreg  = md_reg_q;
      md_wdata = buf_data;
      case (state)
         MD_WAIT: begin
            md_fire  = retire_now;
            md_wreg  = rdy_reg;
            md_wdata = rdy_data;
         end
         MD_HOLD: md_fire = !pipe_we;
         default: md_fire = 1'b0;
      endcase

      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
      if (pipe_we) begin
         ctrl_writeEnable = 1'b1;
         ctrl_writeReg    = pipe_reg;
         data_writeReg    = pipe_data;
      end else if (md_fire && (md_wreg != '0)) begin
         ctrl_writeEnable = 1'b1;
         ctrl_writeReg    = md_wreg;
         data_writeReg    = md_wdata;
      end

      md_busy = (state != MD_IDLE);
      md_dest = md_busy ? md_reg_q : '0;
   end

endmodule

// File: tb/tb_stage_writeback.sv
// Directed bench for stage_writeback: each step drives one cycle of inputs and
// queues the outputs expected in the following cycle.
module tb_stage_writeback;
   import stage_writeback_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_insn = '0;
   logic [31:0] in_alu_result = '0;
   logic [31:0] in_mem_data = '0;
   logic [31:0] in_pc_plus1 = '0;
   logic        in_ovf = 1'b0;
   logic        md_issue = 1'b0;
   logic [4:0]  md_rd = '0;
   logic        md_is_div = 1'b0;
   logic        md_rdy = 1'b0;
   logic [31:0] md_result = '0;
   logic        md_exception = 1'b0;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        md_busy;
   logic [4:0]  md_dest;

   stage_writeback dut (
      .clock            (clock),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_insn          (in_insn),
      .in_alu_result    (in_alu_result),
      .in_mem_data      (in_mem_data),
      .in_pc_plus1      (in_pc_plus1),
      .in_ovf           (in_ovf),
      .md_issue         (md_issue),
      .md_rd            (md_rd),
      .md_is_div        (md_is_div),
      .md_rdy           (md_rdy),
      .md_result        (md_result),
      .md_exception     (md_exception),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .md_busy          (md_busy),
      .md_dest          (md_dest)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [4:0]  rg;
      logic [31:0] data;
      logic        busy;
      logic [4:0]  dest;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   n_step = 0;

   function automatic logic [31:0] rt(input logic [4:0] rd, input logic [4:0] op);
      return {OP_RTYPE, rd, 15'd0, op, 2'd0};
   endfunction

   function automatic logic [31:0] it(input logic [4:0] op, input logic [4:0] rd);
      return {op, rd, 22'd0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL step%0d %s observed=%0h expected=%0h", n_step, tag, obs, exp);
   endtask

   // Drive one cycle at the falling edge, then compare the previous step's expectation.
   task automatic step(
      input logic rst, input logic v, input logic [31:0] insn, input logic [31:0] alu,
      input logic [31:0] mem, input logic [31:0] pc1, input logic ovf,
      input logic iss, input logic [4:0] ird, input logic idiv,
      input logic rdy, input logic [31:0] res, input logic exc,
      input logic e_we, input logic [4:0] e_reg, input logic [31:0] e_data,
      input logic e_busy, input logic [4:0] e_dest);
      exp_t e;
      @(negedge clock);
      reset = rst; in_valid = v; in_insn = insn; in_alu_result = alu;
      in_mem_data = mem; in_pc_plus1 = pc1; in_ovf = ovf;
      md_issue = iss; md_rd = ird; md_is_div = idiv;
      md_rdy = rdy; md_result = res; md_exception = exc;
      sb.push_back('{we: e_we, rg: e_reg, data: e_data, busy: e_busy, dest: e_dest});
      #1;
      if (sb.size() > 1) begin
         e = sb.pop_front();
         chk("we", 32'(ctrl_writeEnable), 32'(e.we));
         if (e.we) begin
            chk("reg", 32'(ctrl_writeReg), 32'(e.rg));
            chk("data", data_writeReg, e.data);
         end
         chk("busy", 32'(md_busy), 32'(e.busy));
         chk("dest", 32'(md_dest), 32'(e.dest));
      end
      n_step++;
   endtask

   initial begin
      // reset, then plain pipeline writes
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
      step(0, 1, rt(3, ALU_ADD), 12, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 3, 12, 0, 0);
      step(0, 0, rt(3, ALU_ADD), 12, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
      step(0, 1, rt(4, ALU_SUB), 99, 0, 0, 1,  0, 0, 0,  0, 0, 0,  1, 30, 3, 0, 0);
      step(0, 1, it(OP_ADDI, 0), 5, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
      step(0, 1, it(OP_JAL, 7), 9, 0, 32'h40, 0,  0, 0, 0,  0, 0, 0,  1, 31, 32'h40, 0, 0);
      step(0, 1, it(OP_LW, 9), 7, 32'hDEADBEEF, 0, 0,  0, 0, 0,  0, 0, 0,  1, 9, 32'hDEADBEEF, 0, 0);
      // mul rd=6 retires on a bubble cycle
      step(0, 0, 0, 0, 0, 0, 0,  1, 6, 0,  0, 0, 0,  0, 0, 0, 1, 6);
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 6, 42, 1, 6);
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 42, 0,  0, 0, 0, 0, 0);
      // md_rdy collides with addi r2: pipeline first, then the buffered mul
      step(0, 1, it(OP_ADDI, 2), 77, 0, 0, 0,  1, 6, 0,  0, 0, 0,  1, 2, 77, 1, 6);
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 42, 0,  1, 6, 42, 1, 6);
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
      // three back-to-back pipeline writes hold the mul result three cycles
      step(0, 0, 0, 0, 0, 0, 0,  1, 6, 0,  0, 0, 0,  0, 0, 0, 1, 6);
      step(0, 1, rt(1, ALU_ADD), 1, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 1, 1, 1, 6);
      step(0, 1, rt(2, ALU_ADD), 2, 0, 0, 0,  0, 0, 0,  1, 42, 0,  1, 2, 2, 1, 6);
      step(0, 1, rt(3, ALU_OR), 3, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 3, 3, 1, 6);
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 6, 42, 1, 6);
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
      // illegal issue in WAIT is ignored; issue on the retiring cycle is accepted
      step(0, 0, 0, 0, 0, 0, 0,  1, 7, 0,  0, 0, 0,  0, 0, 0, 1, 7);
      step(0, 0, 0, 0, 0, 0, 0,  1, 9, 1,  0, 0, 0,  0, 0, 0, 1, 7);
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 7, 100, 1, 7);
      step(0, 0, 0, 0, 0, 0, 0,  1, 8, 1,  1, 100, 0,  0, 0, 0, 1, 8);
      // div exception collides with setx, stays buffered behind add r5, then reset
      step(0, 1, it(OP_SETX, 0), 32'h55, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 30, 32'h55, 1, 8);
      step(0, 1, rt(5, ALU_ADD), 5, 0, 0, 0,  0, 0, 0,  1, 123, 1,  1, 5, 5, 1, 30);
      step(1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
